mesm6_alu_seq: RTL and testbench

MESM6_ALU_SEQ -- requirements
Module: mesm6_alu_seq

---
 rtl/mesm6_pkg.sv | 18 +
 rtl/mesm6_muldiv_iter.sv | 69 ++++++
 rtl/mesm6_alu_seq.sv | 167 ++++++++++++++++
 tb/tb_mesm6_alu_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_pkg.sv
// Shared mesm6 ALU operation codes.
package mesm6_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP              = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_YTA              = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND              = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR               = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR              = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD_CARRY_AROUND = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_COUNT            = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_CLZ              = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SHIFT            = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL              = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV              = 4'd10;

endpackage

// File: rtl/mesm6_muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider, one bit per step.
// hi/lo present the post-step value so the caller can latch on the final step.
module mesm6_muldiv_iter #(
    parameter int WIDTH = 48,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             valid_o
);
    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH-1);

    logic             div_q;
    logic [WIDTH-1:0] m_q, ph_q, pl_q, ph_n, pl_n;
    logic [SHW:0]     cnt_q;
    logic [WIDTH:0]   sum, rsh, diff;

    // MUL: ph:pl is the partial product, pl starts as the multiplier.
    // DIV: ph is the partial remainder, pl shifts dividend out / quotient in.
    always_comb begin
        sum  = {1'b0, ph_q} + {1'b0, {WIDTH{pl_q[0]}} & m_q};
        rsh  = {ph_q, pl_q[WIDTH-1]};
        diff = rsh - {1'b0, m_q};
        if (div_q) begin
            if (diff[WIDTH]) begin
                ph_n = rsh[WIDTH-1:0];
                pl_n = {pl_q[WIDTH-2:0], 1'b0};
            end else begin
                ph_n = diff[WIDTH-1:0];
                pl_n = {pl_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            ph_n = sum[WIDTH:1];
            pl_n = {sum[0], pl_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 1'b0;
            m_q   <= '0;
            ph_q  <= '0;
            pl_q  <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            div_q <= div_i;
            m_q   <= div_i ? b_i : a_i;
            pl_q  <= div_i ? a_i : b_i;
            ph_q  <= '0;
            cnt_q <= '0;
        end else if (step_i) begin
            ph_q  <= ph_n;
            pl_q  <= pl_n;
            cnt_q <= cnt_q + (SHW+1)'(1);
        end
    end

    assign valid_o = step_i && (cnt_q == LAST);
    assign hi_o    = div_q ? pl_n : ph_n;
    assign lo_o    = div_q ? ph_n : pl_n;

endmodule

// File: rtl/mesm6_alu_seq.sv
// mesm6 sequential ALU: single-cycle logic/shift ops, two-cycle end-around adds,
// iterative MUL/DIV. result and y only change when an operation completes.
module mesm6_alu_seq
    import mesm6_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ALU_OP_WIDTH-1:0] op,
    input  logic                    wy,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic [WIDTH-1:0]        result,
    output logic [WIDTH-1:0]        y,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0]        result_q, result_d, y_q, y_d;
    logic [WIDTH-1:0]        acc_q, acc_d, yp_q, yp_d;
    logic                    carry_q, carry_d;

    logic [SHW:0]            pop_cnt, lz_cnt, clz_val;
    logic [WIDTH-1:0]        add_opa;
    logic [WIDTH:0]          add_sum;
    logic [2*WIDTH-1:0]      shr_full, shl_full;
    logic                    eng_start, eng_step, eng_valid;
    logic [WIDTH-1:0]        eng_hi, eng_lo;

    always_comb begin
        pop_cnt = '0;
        lz_cnt  = (SHW+1)'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + (SHW+1)'(a[i]);
            if (a[i]) lz_cnt = (SHW+1)'(WIDTH-1-i);
        end
        clz_val = (a == '0) ? '0 : lz_cnt + (SHW+1)'(1);
    end

    always_comb begin
        case (op)
            ALU_COUNT: add_opa = WIDTH'(pop_cnt);
            ALU_CLZ:   add_opa = WIDTH'(clz_val);
            default:   add_opa = a;
        endcase
        add_sum  = {1'b0, add_opa} + {1'b0, b};
        shr_full = {a, {WIDTH{1'b0}}} >> b[SHW:0];
        shl_full = {{WIDTH{1'b0}}, a} << b[SHW:0];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        y_d       = y_q;
        acc_d     = acc_q;
        yp_d      = yp_q;
        carry_d   = carry_q;
        eng_start = 1'b0;
        eng_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op == ALU_NOP) begin
                    if (wy) y_d = a;
                end else begin
                    op_d    = op;
                    state_d = S_DONE;
                    case (op)
                        ALU_YTA: result_d = y_q;
                        ALU_AND: begin result_d = a & b; y_d = '0; end
                        ALU_OR:  begin result_d = a | b; y_d = '0; end
                        ALU_XOR: begin result_d = a ^ b; y_d = a;  end
                        ALU_ADD_CARRY_AROUND, ALU_COUNT, ALU_CLZ: begin
                            // Staged privately so an abort leaves result/y untouched.
                            {carry_d, acc_d} = add_sum;
                            yp_d    = (op == ALU_CLZ) ? a << clz_val : '0;
                            state_d = S_RUN;
                        end
                        ALU_SHIFT: begin
                            if (b[WIDTH-1]) {result_d, y_d} = shr_full;
                            else            {y_d, result_d} = shl_full;
                        end
                        ALU_MUL: begin
                            eng_start = 1'b1;
                            state_d   = S_RUN;
                        end
                        ALU_DIV: begin
                            if (b == '0) begin
                                result_d = '1;
                                y_d      = a;
                            end else begin
                                eng_start = 1'b1;
                                state_d   = S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (op == ALU_NOP) begin
                    state_d = S_IDLE;
                end else if (op_q == ALU_MUL || op_q == ALU_DIV) begin
                    eng_step = 1'b1;
                    if (eng_valid) begin
                        result_d = eng_hi;
                        y_d      = eng_lo;
                        state_d  = S_DONE;
                    end
                end else begin
                    result_d = acc_q + WIDTH'(carry_q);
                    y_d      = yp_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  if (op == ALU_NOP) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= ALU_NOP;
            result_q <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            yp_q     <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            yp_q     <= yp_d;
            carry_q  <= carry_d;
        end
    end

    mesm6_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (eng_start),
        .step_i  (eng_step),
        .div_i   (op == ALU_DIV),
        .a_i     (a),
        .b_i     (b),
        .hi_o    (eng_hi),
        .lo_o    (eng_lo),
        .valid_o (eng_valid)
    );

    assign result = result_q;
    assign y      = y_q;
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// Directed bench for mesm6_alu_seq with an arithmetic reference model.
module tb_mesm6_alu_seq;
    import mesm6_pkg::*;

    localparam int W   = 48;
    localparam int SHW = $clog2(W);

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    wy = 1'b0;
    logic [ALU_OP_WIDTH-1:0] op = ALU_NOP;
    logic [W-1:0]            a = '0, b = '0;
    logic [W-1:0]            result, y;
    logic                    busy, done;

    int   checks = 0, errors = 0;
    logic [W-1:0] m_res = '0, m_y = '0;
    logic e_busy = 1'b0, e_done = 1'b0, chk_en = 1'b0, chk_ry = 1'b1;

    mesm6_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .wy(wy), .a(a), .b(b),
        .result(result), .y(y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: what result/y become and how many clocks until done.
    task automatic model(input logic [ALU_OP_WIDTH-1:0] o, input logic [W-1:0] av, bv, yin, rin,
                         output logic [W-1:0] r, yo, output int lat);
        logic [W:0]     s;
        logic [W-1:0]   z, v;
        logic [2*W-1:0] t;
        int             n, k;
        z = '0; r = rin; yo = yin; lat = 1;
        case (o)
            ALU_YTA: r = yin;
            ALU_AND: begin r = av & bv; yo = '0; end
            ALU_OR:  begin r = av | bv; yo = '0; end
            ALU_XOR: begin r = av ^ bv; yo = av; end
            ALU_ADD_CARRY_AROUND, ALU_COUNT, ALU_CLZ: begin
                v = av;
                if (o == ALU_COUNT) v = W'($countones(av));
                if (o == ALU_CLZ) begin
                    v = '0;
                    if (av != '0) begin
                        k = W - 1;
                        while (av[k] == 1'b0) k--;
                        v = W'(W - k);
                    end
                end
                s  = (W+1)'(v) + (W+1)'(bv);
                r  = s[W-1:0] + W'(s[W]);
                yo = (o == ALU_CLZ) ? av << v : '0;
                lat = 2;
            end
            ALU_SHIFT: begin
                n = int'(bv[SHW:0]);
                if (bv[W-1]) begin t = {av, z} >> n; r = t[2*W-1:W]; yo = t[W-1:0]; end
                else         begin t = {z, av} << n; yo = t[2*W-1:W]; r = t[W-1:0]; end
            end
            ALU_MUL: begin
                t = (2*W)'(av) * (2*W)'(bv);
                r = t[2*W-1:W]; yo = t[W-1:0]; lat = W + 1;
            end
            ALU_DIV: begin
                if (bv == '0) begin r = '1; yo = av; end
                else begin r = av / bv; yo = av % bv; lat = W + 1; end
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            if (chk_ry) begin
                chk("result", result, m_res);
                chk("y", y, m_y);
            end
        end
    end

    // Issue op, hold it through DONE for one extra cycle, then drop to NOP.
    task automatic run_op(input logic [ALU_OP_WIDTH-1:0] o, input logic [W-1:0] av, bv,
                          input int chg_at, output int got_lat);
        logic [W-1:0] r, yy;
        int lat;
        model(o, av, bv, m_y, m_res, r, yy, lat);
        got_lat = 0;
        op = o; a = av; b = bv;
        for (int c = 1; c <= lat; c++) begin
            if (c == chg_at) op = ALU_AND;
            @(posedge clk); #1;
            if (done && got_lat == 0) got_lat = c;
            if (c < lat) begin
                e_busy = 1'b1;
                chk_ry = !(o inside {ALU_ADD_CARRY_AROUND, ALU_COUNT, ALU_CLZ});
            end else begin
                e_busy = 1'b0; e_done = 1'b1; chk_ry = 1'b1;
                m_res = r; m_y = yy;
            end
        end
        @(posedge clk); #1;
        op = ALU_NOP;
        @(posedge clk); #1;
        e_done = 1'b0;
    endtask

    task automatic load_y(input logic [W-1:0] v);
        wy = 1'b1; a = v;
        @(posedge clk); #1;
        m_y = v; wy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pr, py;
        int lat;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        load_y(48'h0123_4567_89AB);
        run_op(ALU_YTA, 48'h0, 48'h0, 0, lat);
        chk("yta_res", result, 48'h0123_4567_89AB);
        run_op(ALU_AND, 48'hFF00_FF00_FF00, 48'h0F0F_0F0F_0F0F, 0, lat);
        chk("and_res", result, 48'h0F00_0F00_0F00);
        run_op(ALU_OR,  48'hFF00_FF00_FF00, 48'h0F0F_0F0F_0F0F, 0, lat);
        chk("or_res", result, 48'hFF0F_FF0F_FF0F);
        run_op(ALU_XOR, 48'hFF00_FF00_FF00, 48'h0F0F_0F0F_0F0F, 0, lat);
        chk("xor_res", result, 48'hF00F_F00F_F00F);
        chk("xor_y", y, 48'hFF00_FF00_FF00);

        run_op(ALU_ADD_CARRY_AROUND, 48'hFFFF_FFFF_FFFF, 48'h1, 0, lat);
        chk("aca_res", result, 48'h1);
        chk("aca_lat", lat, 2);
        run_op(ALU_ADD_CARRY_AROUND, 48'h1234, 48'h1000, 0, lat);
        run_op(ALU_COUNT, 48'hF0F0, 48'h3, 0, lat);
        chk("count_res", result, 48'd11);
        run_op(ALU_CLZ, 48'h0000_0F00_0000, 48'h5, 0, lat);
        chk("clz_res", result, 48'd26);
        chk("clz_y", y, 48'hE000_0000_0000);
        run_op(ALU_CLZ, 48'h0, 48'h9, 0, lat);

        run_op(ALU_SHIFT, 48'h1, 48'h8000_0000_0001, 0, lat);
        chk("shr_res", result, 48'h0);
        chk("shr_y", y, 48'h8000_0000_0000);
        run_op(ALU_SHIFT, 48'h1, 48'd47, 0, lat);
        chk("shl_res", result, 48'h8000_0000_0000);
        chk("shl_y", y, 48'h0);
        run_op(ALU_SHIFT, 48'hABCD_EF01_2345, 48'd60, 0, lat);

        run_op(ALU_MUL, 48'hFFFF_FFFF_FFFF, 48'h2, 0, lat);
        chk("mul_res", result, 48'h1);
        chk("mul_y", y, 48'hFFFF_FFFF_FFFE);
        chk("mul_lat", lat, 49);
        run_op(ALU_MUL, 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 0, lat);
        run_op(ALU_MUL, 48'h0000_0000_1234, 48'h0000_0000_0100, 6, lat);

        run_op(ALU_DIV, 48'd100, 48'd7, 0, lat);
        chk("div_res", result, 48'd14);
        chk("div_y", y, 48'd2);
        chk("div_lat", lat, 49);
        run_op(ALU_DIV, 48'd5, 48'd0, 0, lat);
        chk("div0_res", result, 48'hFFFF_FFFF_FFFF);
        chk("div0_y", y, 48'd5);
        chk("div0_lat", lat, 1);
        run_op(ALU_DIV, 48'hFFFF_FFFF_FFFF, 48'h1_0001, 0, lat);

        run_op(4'hF, 48'h1111, 48'h2222, 0, lat);
        chk("unk_lat", lat, 1);

        // Abort a MUL: op drops to NOP before the 10th clock.
        pr = m_res; py = m_y;
        op = ALU_MUL; a = 48'hABC; b = 48'h123;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            e_busy = 1'b1;
        end
        op = ALU_NOP;
        @(posedge clk); #1;
        e_busy = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res", result, pr);
        chk("abort_y", y, py);

        // Reset pulse in the middle of a DIV.
        op = ALU_DIV; a = 48'd1000; b = 48'd3;
        repeat (5) begin
            @(posedge clk); #1;
            e_busy = 1'b1;
        end
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rrun_result", result, 0);
        chk("rrun_y", y, 0);
        chk("rrun_busy", busy, 0);
        chk("rrun_done", done, 0);
        op = ALU_NOP; m_res = '0; m_y = '0; e_busy = 1'b0; e_done = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        run_op(ALU_DIV, 48'd100, 48'd7, 0, lat);
        chk("fresh_div_res", result, 48'd14);
        chk("fresh_div_lat", lat, 49);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
